// File: rtl/regfile_write_scheduler_pkg.sv
// Shared widths, register count and FSM encoding for the register-file write scheduler.
package regfile_write_scheduler_pkg;

    localparam int REG_CODE_W = 4;
    localparam int DATA_W     = 16;
    localparam int NUM_REGS   = 16;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: one-hot grant, pointer favours the last loser.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);
    import regfile_write_scheduler_pkg::*;

    logic ptr_reg;
    logic ptr_next;

    always_comb begin
        grant    = 2'b00;
        ptr_next = ptr_reg;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_reg ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        // The pointer only moves on a grant, and then names the other requester.
        if (grant[0]) begin
            ptr_next = 1'b1;
        end else if (grant[1]) begin
            ptr_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Register-file write port scheduler: sweeps INIT_VALUE into every register, then
// merges ALU and load writebacks onto the single write port with round-robin fairness.
module regfile_write_scheduler #(
    parameter logic [regfile_write_scheduler_pkg::DATA_W-1:0] INIT_VALUE = 16'h0000,
    parameter int NUM_REGS = regfile_write_scheduler_pkg::NUM_REGS
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          clear,
    input  logic                                          req0,
    input  logic                                          req1,
    input  logic [regfile_write_scheduler_pkg::REG_CODE_W-1:0] code0,
    input  logic [regfile_write_scheduler_pkg::REG_CODE_W-1:0] code1,
    input  logic [regfile_write_scheduler_pkg::DATA_W-1:0]     data0,
    input  logic [regfile_write_scheduler_pkg::DATA_W-1:0]     data1,
    output logic                                          ack0,
    output logic                                          ack1,
    output logic [regfile_write_scheduler_pkg::REG_CODE_W-1:0] write_code,
    output logic [regfile_write_scheduler_pkg::DATA_W-1:0]     w_data,
    output logic                                          w_flag,
    output logic                                          ready
);
    import regfile_write_scheduler_pkg::*;

    localparam logic [REG_CODE_W-1:0] LAST_CODE = REG_CODE_W'(NUM_REGS - 1);

    state_t                state_reg, state_next;
    logic [REG_CODE_W-1:0] count_reg, count_next;
    logic [REG_CODE_W-1:0] code_reg, code_next;
    logic [DATA_W-1:0]     data_reg, data_next;
    logic                  flag_reg, flag_next;
    logic [1:0]            ack_reg, ack_next;
    logic [1:0]            req_vec;
    logic [1:0]            eligible;
    logic [1:0]            grant;
    logic                  arb_en;

    assign req_vec = {req1, req0};
    // A clear outranks any request, so the arbiter is muted in that cycle.
    assign arb_en  = (state_reg == RUN) && !clear;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_elig
            assign eligible[gi] = req_vec[gi] & ~ack_reg[gi] & arb_en;
        end
    endgenerate

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .eligible (eligible),
        .grant    (grant)
    );

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        code_next  = code_reg;
        data_next  = data_reg;
        flag_next  = 1'b0;
        ack_next   = 2'b00;
        case (state_reg)
            INIT: begin
                flag_next  = 1'b1;
                code_next  = count_reg;
                data_next  = INIT_VALUE;
                count_next = count_reg + 1'b1;
                if (count_reg == LAST_CODE) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (clear) begin
                    // Re-entering INIT issues index 0 on this same edge.
                    state_next = INIT;
                    flag_next  = 1'b1;
                    code_next  = '0;
                    data_next  = INIT_VALUE;
                    count_next = REG_CODE_W'(1);
                end else if (grant != 2'b00) begin
                    flag_next = 1'b1;
                    code_next = grant[1] ? code1 : code0;
                    data_next = grant[1] ? data1 : data0;
                    ack_next  = grant;
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= INIT;
            count_reg <= '0;
            code_reg  <= '0;
            data_reg  <= '0;
            flag_reg  <= 1'b0;
            ack_reg   <= 2'b00;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            code_reg  <= code_next;
            data_reg  <= data_next;
            flag_reg  <= flag_next;
            ack_reg   <= ack_next;
        end
    end

    assign ack0       = ack_reg[0];
    assign ack1       = ack_reg[1];
    assign write_code = code_reg;
    assign w_data     = data_reg;
    assign w_flag     = flag_reg;
    assign ready      = (state_reg == RUN);

endmodule
